// File: rtl/fft_shift_pkg.sv
// fft_shift_pkg: shared defaults and controller state encoding for the FFT shift controller.
package fft_shift_pkg;
    localparam int N_STAGES_DEF = 11;
    localparam int OF_CNT_W_DEF = 16;
    typedef enum logic {WAIT_SYNC, RUN} state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter; a clear beats a simultaneous increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count <= '0;
        else if (clr) count <= '0;
        else if (inc && count != '1) count <= count + W'(1);
    end
endmodule

// File: rtl/fft_shift_ctrl.sv
// fft_shift_ctrl: frame-aligned FFT shift schedule loader with per-frame overflow tracking.
module fft_shift_ctrl
    import fft_shift_pkg::*;
#(
    parameter int N_STAGES = N_STAGES_DEF,
    parameter int OF_CNT_W = OF_CNT_W_DEF
) (
    input  logic                user_clk,
    input  logic                user_rst,
    input  logic [31:0]         shift_reg,
    input  logic                sync_in,
    input  logic                of_in,
    input  logic                of_clr,
    output logic [N_STAGES-1:0] shift_out,
    output logic                sync_out,
    output logic                shift_changed,
    output logic                of_frame,
    output logic [OF_CNT_W-1:0] of_count
);
    state_t state, state_nxt;
    logic [N_STAGES-1:0] cand, pending;
    logic acc, frame_close, unused_bits;

    assign unused_bits = ^shift_reg;
    assign frame_close = (state == RUN) && sync_in;

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) state <= WAIT_SYNC;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = (state == WAIT_SYNC && sync_in) ? RUN : state;
    end

    // A word is accepted only once it has been seen on two consecutive cycles.
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            cand          <= '1;
            pending       <= '1;
            shift_out     <= '1;
            sync_out      <= 1'b0;
            shift_changed <= 1'b0;
            acc           <= 1'b0;
            of_frame      <= 1'b0;
        end else begin
            cand          <= shift_reg[N_STAGES-1:0];
            sync_out      <= sync_in;
            shift_changed <= sync_in && (pending != shift_out);
            if (shift_reg[N_STAGES-1:0] == cand) pending <= cand;
            if (sync_in) shift_out <= pending;
            if (frame_close) of_frame <= acc;
            if (sync_in) acc <= of_in;
            else if (state == RUN) acc <= acc | of_in;
        end
    end

    sat_counter #(.W(OF_CNT_W)) u_of_cnt (
        .clk   (user_clk),
        .rst   (user_rst),
        .clr   (of_clr),
        .inc   (frame_close && acc),
        .count (of_count)
    );
endmodule

// File: tb/tb_fft_shift_ctrl.sv
// tb_fft_shift_ctrl: directed checks of schedule loading, stability filtering and overflow counting.
module tb_fft_shift_ctrl;
    logic        user_clk = 1'b0;
    logic        user_rst = 1'b1;
    logic [31:0] shift_reg = '0;
    logic        sync_in = 1'b0;
    logic        of_in = 1'b0;
    logic        of_clr = 1'b0;
    logic [10:0] shift_out;
    logic        sync_out, shift_changed, of_frame;
    logic [1:0]  of_count;
    int          n_tests = 0;
    int          n_fail = 0;

    fft_shift_ctrl #(.N_STAGES(11), .OF_CNT_W(2)) dut (
        .user_clk      (user_clk),
        .user_rst      (user_rst),
        .shift_reg     (shift_reg),
        .sync_in       (sync_in),
        .of_in         (of_in),
        .of_clr        (of_clr),
        .shift_out     (shift_out),
        .sync_out      (sync_out),
        .shift_changed (shift_changed),
        .of_frame      (of_frame),
        .of_count      (of_count)
    );

    always #5 user_clk = ~user_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge user_clk);
            #1;
        end
    endtask

    task automatic sync_tick(input logic ov, input logic clr);
        sync_in = 1'b1; of_in = ov; of_clr = clr;
        tick();
        sync_in = 1'b0; of_in = 1'b0; of_clr = 1'b0;
    endtask

    task automatic ov_tick();
        of_in = 1'b1;
        tick();
        of_in = 1'b0;
    endtask

    initial begin
        tick(3);
        check("rst_shift", 32'(shift_out), 32'h7FF);
        check("rst_sync", 32'(sync_out), 0);
        check("rst_chg", 32'(shift_changed), 0);
        check("rst_of_frame", 32'(of_frame), 0);
        check("rst_count", 32'(of_count), 0);
        user_rst = 1'b0;
        of_in = 1'b1;
        tick(3);
        of_in = 1'b0;
        tick();
        check("wait_shift", 32'(shift_out), 32'h7FF);
        check("wait_of_frame", 32'(of_frame), 0);
        check("wait_count", 32'(of_count), 0);

        shift_reg = 32'h555;
        tick(3);
        sync_tick(1'b0, 1'b0);
        check("load_shift", 32'(shift_out), 32'h555);
        check("load_sync", 32'(sync_out), 1);
        check("load_chg", 32'(shift_changed), 1);
        tick();
        check("load_sync_low", 32'(sync_out), 0);
        check("load_chg_low", 32'(shift_changed), 0);
        tick(2);
        sync_tick(1'b0, 1'b0);
        check("same_shift", 32'(shift_out), 32'h555);
        check("same_chg", 32'(shift_changed), 0);
        check("same_sync", 32'(sync_out), 1);

        for (int i = 0; i < 3; i++) begin
            shift_reg = i[0] ? 32'h555 : 32'h0AA;
            tick();
        end
        shift_reg = 32'h555;
        sync_tick(1'b0, 1'b0);
        check("unstable_shift", 32'(shift_out), 32'h555);
        check("unstable_chg", 32'(shift_changed), 0);
        shift_reg = 32'h0AA;
        tick();
        shift_reg = 32'h555;
        tick();
        shift_reg = 32'h0AA;
        tick(3);
        sync_tick(1'b0, 1'b0);
        check("stable_shift", 32'(shift_out), 32'h0AA);
        check("stable_chg", 32'(shift_changed), 1);
        check("stable_of_frame", 32'(of_frame), 0);

        ov_tick();
        tick();
        sync_tick(1'b0, 1'b0);
        check("f1_of_frame", 32'(of_frame), 1);
        check("f1_count", 32'(of_count), 1);
        tick(3);
        sync_tick(1'b0, 1'b0);
        check("f2_of_frame", 32'(of_frame), 0);
        check("f2_count", 32'(of_count), 1);
        tick();
        ov_tick();
        tick();
        sync_tick(1'b0, 1'b0);
        check("f3_of_frame", 32'(of_frame), 1);
        check("f3_count", 32'(of_count), 2);

        ov_tick();
        sync_tick(1'b0, 1'b0);
        check("sat_count_3", 32'(of_count), 3);
        ov_tick();
        sync_tick(1'b0, 1'b0);
        check("sat_hold", 32'(of_count), 3);
        ov_tick();
        sync_tick(1'b0, 1'b1);
        check("clr_wins", 32'(of_count), 0);
        check("clr_of_frame", 32'(of_frame), 1);

        tick();
        sync_tick(1'b1, 1'b0);
        check("b2b_first_frame", 32'(of_frame), 0);
        check("b2b_first_count", 32'(of_count), 0);
        sync_tick(1'b0, 1'b0);
        check("b2b_second_frame", 32'(of_frame), 1);
        check("b2b_second_count", 32'(of_count), 1);
        check("b2b_sync", 32'(sync_out), 1);
        check("b2b_chg", 32'(shift_changed), 0);
        of_clr = 1'b1;
        tick();
        of_clr = 1'b0;
        check("clr_alone", 32'(of_count), 0);

        ov_tick();
        sync_tick(1'b0, 1'b0);
        check("pre_rst_frame", 32'(of_frame), 1);
        check("pre_rst_count", 32'(of_count), 1);
        of_in = 1'b1;
        tick();
        user_rst = 1'b1;
        tick();
        check("mid_rst_frame", 32'(of_frame), 0);
        check("mid_rst_count", 32'(of_count), 0);
        check("mid_rst_shift", 32'(shift_out), 32'h7FF);
        user_rst = 1'b0;
        tick(3);
        of_in = 1'b0;
        sync_tick(1'b0, 1'b0);
        check("resync_frame", 32'(of_frame), 0);
        check("resync_count", 32'(of_count), 0);
        check("resync_shift", 32'(shift_out), 32'h0AA);
        check("resync_chg", 32'(shift_changed), 1);
        tick(2);
        sync_tick(1'b0, 1'b0);
        check("post_rst_frame", 32'(of_frame), 0);
        check("post_rst_count", 32'(of_count), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
